// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake bundle for seq_det_ctrl: pattern, length, mode and
// target offered by the control side under valid/ready.
interface seq_det_ctrl_if #(
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output cfg_ready
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with match counting and target completion.
// Define SEQ_DET_OVERLAP_EN to honour cfg_overlap; otherwise detection is always non-overlapping.
module seq_det_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave cfg,
  input  logic          start,
  input  logic          abort,
  input  logic          din_valid,
  input  logic          din,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic          loaded_q, loaded_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] mcnt_q, mcnt_d;
  logic          match_q, match_d;
`ifdef SEQ_DET_OVERLAP_EN
  logic          ovl_q, ovl_d;
`else
  logic          unused_overlap;
  assign unused_overlap = cfg.cfg_overlap;
`endif

  logic          hs;
  logic [3:0]    len_clamp;
  logic [PW-1:0] mask;
  logic [PW-1:0] hist_sh;
  logic [3:0]    cnt_inc;
  logic [CW-1:0] mcnt_inc;
  logic          hit;
  logic          clear_cnt;

  assign hs       = cfg.cfg_valid && (state_q != RUN);
  assign hist_sh  = {hist_q[PW-2:0], din};
  assign cnt_inc  = (cnt_q < len_q) ? cnt_q + 4'd1 : cnt_q;
  assign mcnt_inc = mcnt_q + CW'(1);
  assign hit      = (cnt_inc >= len_q) && ((hist_sh & mask) == (pat_q & mask));
`ifdef SEQ_DET_OVERLAP_EN
  assign clear_cnt = !ovl_q;
`else
  assign clear_cnt = 1'b1;
`endif

  always_comb begin
    len_clamp = cfg.cfg_len;
    if (cfg.cfg_len == 4'd0)
      len_clamp = 4'd1;
    else if (cfg.cfg_len > 4'(PW))
      len_clamp = 4'(PW);
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PW; i++)
      mask[i] = (i < 32'(len_q));
  end

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    pat_d    = pat_q;
    len_d    = len_q;
    tgt_d    = tgt_q;
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    mcnt_d   = mcnt_q;
    match_d  = 1'b0;
`ifdef SEQ_DET_OVERLAP_EN
    ovl_d    = ovl_q;
`endif
    if (abort) begin
      state_d = IDLE;
      hist_d  = '0;
      cnt_d   = '0;
    end else begin
      if (hs) begin
        loaded_d = 1'b1;
        pat_d    = cfg.cfg_pattern;
        len_d    = len_clamp;
        tgt_d    = cfg.cfg_target;
`ifdef SEQ_DET_OVERLAP_EN
        ovl_d    = cfg.cfg_overlap;
`endif
      end
      case (state_q)
        IDLE, DONE: begin
          // loaded_q is always set in DONE, so one condition covers both states
          if (start && loaded_q && !hs) begin
            state_d = RUN;
            hist_d  = '0;
            cnt_d   = '0;
            mcnt_d  = '0;
          end
        end
        RUN: begin
          if (din_valid) begin
            hist_d = hist_sh;
            cnt_d  = cnt_inc;
            if (hit) begin
              match_d = 1'b1;
              mcnt_d  = mcnt_inc;
              if (clear_cnt)
                cnt_d = '0;
              if ((tgt_q != '0) && (mcnt_inc == tgt_q))
                state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      loaded_q <= 1'b0;
      pat_q    <= '0;
      len_q    <= 4'd1;
      tgt_q    <= '0;
      hist_q   <= '0;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      match_q  <= 1'b0;
`ifdef SEQ_DET_OVERLAP_EN
      ovl_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      tgt_q    <= tgt_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      match_q  <= match_d;
`ifdef SEQ_DET_OVERLAP_EN
      ovl_q    <= ovl_d;
`endif
    end
  end

  assign cfg.cfg_ready = (state_q != RUN);
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign match         = match_q;
  assign match_cnt     = mcnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_seq_det_ctrl;
  localparam int PW = 8;
  localparam int CW = 8;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL_EN = 1'b1;
`else
  localparam bit OVL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          din_valid = 1'b0;
  logic          din = 1'b0;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          busy;
  logic          done;

  seq_det_ctrl_if #(.PW(PW), .CW(CW)) cfg_if ();

  seq_det_ctrl #(.PW(PW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .start     (start),
    .abort     (abort),
    .din_valid (din_valid),
    .din       (din),
    .match     (match),
    .match_cnt (match_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last len accepted bits live in a queue; a match is a
  // full queue equal to the pattern. Non-overlapping mode empties the queue.
  bit            m_loaded = 1'b0;
  bit            m_run    = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_match  = 1'b0;
  bit            m_ovl    = 1'b0;
  bit            m_hs     = 1'b0;
  int            m_pat    = 0;
  int            m_len    = 1;
  int            m_tgt    = 0;
  int            m_v      = 0;
  logic [CW-1:0] m_cnt    = '0;
  bit            m_q[$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_loaded = 1'b0;
      m_run    = 1'b0;
      m_done   = 1'b0;
      m_match  = 1'b0;
      m_cnt    = '0;
      m_q.delete();
    end else begin
      m_match = 1'b0;
      m_hs    = cfg_if.cfg_valid && !m_run;
      if (abort) begin
        m_run  = 1'b0;
        m_done = 1'b0;
        m_q.delete();
      end else begin
        if (m_hs) begin
          m_loaded = 1'b1;
          m_pat    = int'(cfg_if.cfg_pattern);
          m_len    = (cfg_if.cfg_len == 0) ? 1 :
                     (int'(cfg_if.cfg_len) > PW) ? PW : int'(cfg_if.cfg_len);
          m_ovl    = OVL_EN && cfg_if.cfg_overlap;
          m_tgt    = int'(cfg_if.cfg_target);
        end
        if (!m_run) begin
          if (start && !m_hs && m_loaded) begin
            m_run  = 1'b1;
            m_done = 1'b0;
            m_cnt  = '0;
            m_q.delete();
          end
        end else if (din_valid) begin
          m_q.push_back(din);
          if (m_q.size() > m_len) void'(m_q.pop_front());
          if (m_q.size() == m_len) begin
            m_v = 0;
            foreach (m_q[i]) m_v = (m_v << 1) | int'(m_q[i]);
            if (m_v == (m_pat & ((1 << m_len) - 1))) begin
              m_match = 1'b1;
              m_cnt++;
              if (!m_ovl) m_q.delete();
              if (m_tgt != 0 && int'(m_cnt) == m_tgt) begin
                m_run  = 1'b0;
                m_done = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("match",     match,            m_match);
    chk("match_cnt", match_cnt,        m_cnt);
    chk("busy",      busy,             m_run);
    chk("done",      done,             m_done);
    chk("cfg_ready", cfg_if.cfg_ready, !m_run);
  end

  task automatic drv(input bit cv, input bit st, input bit ab, input bit dv, input bit d);
    @(negedge clk);
    cfg_if.cfg_valid = cv;
    start            = st;
    abort            = ab;
    din_valid        = dv;
    din              = d;
  endtask

  task automatic bit_in(input bit d);
    drv(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_abort();
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(b[i]);
  endtask

  task automatic set_cfg(input logic [PW-1:0] p, input logic [3:0] l, input bit o,
                         input logic [CW-1:0] t);
    cfg_if.cfg_pattern = p;
    cfg_if.cfg_len     = l;
    cfg_if.cfg_overlap = o;
    cfg_if.cfg_target  = t;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_pattern = '0;
    cfg_if.cfg_len     = '0;
    cfg_if.cfg_overlap = 1'b0;
    cfg_if.cfg_target  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_busy",  busy,             0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_cnt",   match_cnt,        0);

    do_start(); idle();
    chk("start_nocfg", busy, 0);

    cfg_if.cfg_pattern = 8'h05;
    cfg_if.cfg_len     = 4'd3;
    cfg_if.cfg_overlap = 1'b1;
    cfg_if.cfg_target  = '0;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle();
    chk("start_hs", busy, 0);
    do_start(); idle();
    chk("start_ok", busy, 1);

    feed(16'b101, 3); bit_in(1'b0);
    chk("ovl_m3",  match,     1);
    chk("ovl_c3",  match_cnt, 1);
    bit_in(1'b1); idle();
    chk("ovl_m5",  match,     OVL_EN ? 1 : 0);
    chk("ovl_cnt", match_cnt, OVL_EN ? 2 : 1);

    cfg_if.cfg_pattern = 8'hFF;
    repeat (3) drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ready_run", cfg_if.cfg_ready, 0);
    idle();
    chk("cfg_held", match_cnt, OVL_EN ? 2 : 1);
    do_abort(); idle();
    chk("abort_idle", busy, 0);

    set_cfg(8'h05, 4'd3, 1'b0, '0);
    do_start();
    feed(16'b10101, 5); idle();
    chk("novl_cnt", match_cnt, 1);
    do_abort();

    set_cfg(8'h05, 4'd3, 1'b1, 8'd2);
    do_start();
    feed(16'b10101, 5); idle();
    chk("tgt_done5", done, OVL_EN ? 1 : 0);
    chk("tgt_busy5", busy, OVL_EN ? 0 : 1);
    feed(16'b101, 3); idle();
    chk("tgt_done8", done,      1);
    chk("tgt_cnt",   match_cnt, 2);
    do_start(); idle();
    chk("restart_busy", busy,      1);
    chk("restart_cnt",  match_cnt, 0);

    feed(16'b101, 3); bit_in(1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); idle();
    chk("abort_match", match,     0);
    chk("abort_busy",  busy,      0);
    chk("abort_cnt",   match_cnt, 1);

    do_start();
    bit_in(1'b1); idle(); bit_in(1'b0); idle(); idle(); bit_in(1'b1); idle();
    chk("gap_match", match,     1);
    chk("gap_cnt",   match_cnt, 1);
    do_abort();

    set_cfg(8'h01, 4'd0, 1'b1, '0);
    do_start();
    feed(16'b1101, 4); idle();
    chk("len0_cnt", match_cnt, 3);
    do_abort();

    set_cfg(8'hA5, 4'd12, 1'b1, '0);
    do_start();
    feed(16'h00A5, 8); idle();
    chk("lenmax_match", match, 1);

    feed(16'b10, 2);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy",  busy,             0);
    chk("arst_ready", cfg_if.cfg_ready, 1);
    chk("arst_cnt",   match_cnt,        0);
    chk("arst_match", match,            0);
    @(negedge clk);
    rst = 1'b1;
    do_start(); idle();
    chk("arst_start", busy, 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller. It accepts a pattern configuration through a valid/ready handshake, then arms and runs a Moore-style detector on a serial bit stream, in either overlapping or non-overlapping mode. It counts matches up to a programmed target and reports completion. It sits between the control/register side, which configures and starts it, and a serial data source, and generalises the fixed-pattern detectors used elsewhere in the design.

## Interface
- `PW`, default 8: maximum pattern length in bits (legal range 2..15).
- `CW`, default 8: width of the match counter and the target.

- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous reset, active-low (0 = reset).
- `cfg_valid`, in, 1: configuration offered.
- `cfg_ready`, out, 1: configuration can be accepted.
- `cfg_pattern`, in, PW: pattern bits. Bit 0 is the newest (last-received) bit.
- `cfg_len`, in, 4: pattern length. 0 is treated as 1; values above PW are treated as PW.
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `cfg_target`, in, CW: number of matches before completion. 0 = run forever.
- `start`, in, 1: begin a run (level sampled each cycle).
- `abort`, in, 1: stop the run and return to IDLE.
- `din_valid`, in, 1: `din` is valid this cycle.
- `din`, in, 1: serial data bit.
- `match`, out, 1: registered one-cycle pulse per detected pattern.
- `match_cnt`, out, CW: matches detected since the last accepted start.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.

## Operation
- **States:** IDLE, RUN, DONE. All are held in registers. Outputs decode from state and registers only (Moore).
- **Configuration handshake:**
  - `cfg_ready` = 1 in IDLE and DONE, 0 in RUN.
  - The handshake (`cfg_valid` & `cfg_ready`) captures pattern, len (after clamping), overlap and target, and sets the internal `cfg_loaded` flag.
  - A handshake in DONE does not change state.
- **IDLE:**
  - `start` & `cfg_loaded` & no handshake this cycle → RUN.
  - Entering RUN clears the history shift register, the valid-bit count and `match_cnt`.
  - `start` without `cfg_loaded` is ignored.
- **RUN, per cycle with `din_valid` = 1:**
  - Shift `din` into history at bit 0.
  - Increment the valid-bit count, saturating at len.
  - A match occurs when count ≥ len (counting the current bit) and history[len-1:0] == pattern[len-1:0].
  - On a match: `match` is pulsed on the next cycle and `match_cnt` increments, wrapping modulo 2^CW.
  - In non-overlapping mode, a match also resets the valid-bit count to 0.
  - Cycles with `din_valid` = 0 leave the history unchanged.
- **Target:** when target ≠ 0 and the incremented `match_cnt` == target, RUN → DONE on the same edge.
- **DONE:**
  - `din` is ignored.
  - `match_cnt` holds its value.
  - `start` (with no handshake that cycle) → RUN, clearing as above.
- **Abort:** `abort` in any state → IDLE. It clears the history and count, holds `match_cnt`, and keeps the configuration.
- **Priority, highest first:** `rst`, `abort`, configuration handshake, `start`, data.

## Timing
- **Reset values:**
  - state = IDLE, `cfg_loaded` = 0, history = 0, count = 0.
  - Outputs: `match` = 0, `match_cnt` = 0, `busy` = 0, `done` = 0, `cfg_ready` = 1.
- **Start latency:** `start` sampled at edge N → `busy` = 1 after edge N. The first data bit accepted is at edge N+1.
- **Match latency:** the bit completing the pattern, sampled at edge N, gives `match` = 1 and an updated `match_cnt` after edge N, for exactly one cycle.
- **Completion:** `done` rises in the same cycle as the final `match` pulse, and `busy` falls in that cycle.
- **Reset mid-run:** asynchronous. All outputs go to their reset values immediately. `cfg_loaded` is cleared, so a new configuration is required.
- **Abort mid-run:** takes effect at the next edge. A match that would complete on that edge is suppressed.

## Configuration
- **`SEQ_DET_OVERLAP_EN` defined:** `cfg_overlap` is honoured as described.
- **`SEQ_DET_OVERLAP_EN` undefined:**
  - `cfg_overlap` is ignored.
  - Detection is always non-overlapping: the count resets after every match.
  - The captured overlap register is not implemented.

## Test plan
- **Overlapping detection:** pattern 3'b101, len 3, overlap 1, target 0; stream 1,0,1,0,1 → `match` pulses after the 3rd and 5th bits; `match_cnt` = 2.
- **Non-overlapping detection:** same stream with overlap 0, or the macro undefined → single pulse after the 3rd bit; `match_cnt` = 1.
- **Target completion:** target 2, overlap 1, stream 1,0,1,0,1,1,0,1:
  - `done` = 1 and `busy` = 0 in the cycle after the 5th bit.
  - Later bits produce no pulses; `match_cnt` holds 2.
  - `start` restarts the run with `match_cnt` = 0.
- **Handshake gating:**
  - In RUN, `cfg_valid` held high → `cfg_ready` = 0 and the configuration is unchanged.
  - `start` before any configuration → stays IDLE.
  - `start` with a same-cycle handshake → stays IDLE.
  - A later `start` → RUN.
- **Abort and gaps:**
  - `abort` in the same cycle as the completing bit of 101 → no pulse; IDLE next cycle; `match_cnt` held.
  - `din_valid` gaps inside 1,0,1 → match still detected.
- **Asynchronous reset mid-run:** assert `rst` = 0 between edges → outputs reset immediately; `start` after release with no new configuration is ignored.
